// File: rtl/nibble_i2c_pkg.sv
// Shared constants for the nibble transmitter: FSM states, per-state
// durations in timing units, and frame geometry.
package nibble_i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      LOW_A,
      LOW_B,
      HIGH,
      STOP
   } state_t;

   localparam int START_UNITS = 2;
   localparam int LOW_A_UNITS = 1;
   localparam int LOW_B_UNITS = 1;
   localparam int HIGH_UNITS  = 2;
   localparam int STOP_UNITS  = 2;

   localparam int NBITS       = 4;
   localparam int FRAME_UNITS = 24;

   function automatic int state_units(input state_t s);
      int units;
      units = 1;
      case (s)
         START:   units = START_UNITS;
         LOW_A:   units = LOW_A_UNITS;
         LOW_B:   units = LOW_B_UNITS;
         HIGH:    units = HIGH_UNITS;
         STOP:    units = STOP_UNITS;
         default: units = 1;
      endcase
      return units;
   endfunction

endpackage

// File: rtl/i2c_unit_timer.sv
// Divides the system clock into timing units: one-cycle tick every CLK_DIV
// cycles, realigned by a synchronous clear when a frame is accepted.
module i2c_unit_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [W-1:0] count;

   assign tick = (count == W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/nibble_i2c_tx.sv
// Push-pull scl/sda frame generator: START, four data bits MSB first,
// one zero trailer clock, then STOP. All outputs are registered.
module nibble_i2c_tx
   import nibble_i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] data,
   output logic       scl,
   output logic       sda,
   output logic       busy,
   output logic       done
);

   state_t     state;
   state_t     state_nx;
   logic [1:0] unit_cnt;
   logic [2:0] bit_idx;
   logic [3:0] shreg;
   logic       accept;
   logic       tick;
   logic       unit_last;
   logic       scl_nx;
   logic       sda_nx;
   logic       done_nx;

   assign accept    = start && !busy;
   assign unit_last = tick && (unit_cnt == 2'(state_units(state) - 1));

   i2c_unit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (accept),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         scl   <= 1'b1;
         sda   <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         scl   <= scl_nx;
         sda   <= sda_nx;
         busy  <= (state_nx != IDLE);
         done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)    state_nx = START;
         START:   if (unit_last) state_nx = LOW_A;
         LOW_A:   if (unit_last) state_nx = LOW_B;
         LOW_B:   if (unit_last) state_nx = HIGH;
         HIGH:    if (unit_last) state_nx = (bit_idx == 3'(NBITS)) ? STOP : LOW_A;
         STOP:    if (unit_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Line levels are decided from the state being entered so that each
   // register lands on the first cycle of that state.
   always_comb begin
      scl_nx  = 1'b1;
      sda_nx  = 1'b1;
      done_nx = (state == STOP) && unit_last;
      case (state_nx)
         START: begin
            sda_nx = 1'b0;
         end
         LOW_A: begin
            scl_nx = 1'b0;
            sda_nx = sda;
         end
         LOW_B: begin
            scl_nx = 1'b0;
            sda_nx = shreg[3];
         end
         HIGH: begin
            sda_nx = shreg[3];
         end
         default: begin
            scl_nx = 1'b1;
            sda_nx = 1'b1;
         end
      endcase
   end

   // Shifting in zeros leaves the trailer bit at shreg[3] after four bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unit_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else if (accept) begin
         unit_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= data;
      end else if (unit_last) begin
         unit_cnt <= '0;
         if (state == HIGH) begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= {shreg[2:0], 1'b0};
         end
      end else if (tick) begin
         unit_cnt <= unit_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_nibble_i2c_tx.sv
// Bench for nibble_i2c_tx: two instances (CLK_DIV=4 and CLK_DIV=1) checked
// against a unit-level waveform model and a behavioural line receiver.
module tb_nibble_i2c_tx;

   logic            clk = 1'b0;
   logic [1:0]      rst_n_v;
   logic [1:0]      start_v;
   logic [1:0][3:0] data_v;
   logic [1:0]      scl_v;
   logic [1:0]      sda_v;
   logic [1:0]      busy_v;
   logic [1:0]      done_v;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nibble_i2c_tx #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .data(data_v[0]),
      .scl(scl_v[0]), .sda(sda_v[0]), .busy(busy_v[0]), .done(done_v[0])
   );

   nibble_i2c_tx #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .data(data_v[1]),
      .scl(scl_v[1]), .sda(sda_v[1]), .busy(busy_v[1]), .done(done_v[1])
   );

   // Receiver model state, one set per instance.
   logic        prev_scl [2];
   logic        prev_sda [2];
   bit          in_frame [2];
   int          nrise [2];
   logic [4:0]  shift_in [2];
   logic [4:0]  last_bits [2];
   int          last_rise [2];
   logic [15:0] outhigh [2];
   int          frames_seen [2];
   bit          mon_en [2];

   typedef struct {
      int          d;
      logic [3:0]  code;
      logic [15:0] exp_out;
   } vec_t;

   function automatic int div_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   // The receiver lights output (code-1) mod 16.
   function automatic logic [15:0] rx_map(input logic [3:0] code);
      return 16'h0001 << ((int'(code) + 15) % 16);
   endfunction

   // Expected line levels k cycles after acceptance, from the unit schedule.
   function automatic void exp_lines(input int dv, input logic [3:0] code, input int k,
                                     output logic es, output logic ea);
      int u, b, p;
      logic cur, prv;
      u = (k - 1) / dv;
      es = 1'b1;
      ea = 1'b1;
      if (u < 2) begin
         ea = 1'b0;
      end else if (u < 22) begin
         b   = (u - 2) / 4;
         p   = (u - 2) % 4;
         cur = (b < 4) ? code[3-b] : 1'b0;
         prv = (b == 0) ? 1'b0 : code[4-b];
         es  = (p >= 2);
         ea  = (p == 0) ? prv : cur;
      end
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic s, a, ok;
         s = scl_v[d];
         a = sda_v[d];
         if (mon_en[d] && (s != prev_scl[d] || a != prev_sda[d])) begin
            ok = !(s != prev_scl[d] && a != prev_sda[d]);
            if (prev_scl[d] && s && a != prev_sda[d])
               ok = ok && ((!a && !in_frame[d]) || (a && in_frame[d] && nrise[d] == 5));
            checks++;
            if (!ok) begin
               errors++;
               $display("[TB] FAIL line_rule dut%0d at %0t: scl/sda %b%b -> %b%b, required one change, sda steady while scl high",
                        d, $time, prev_scl[d], prev_sda[d], s, a);
            end
         end
         if (prev_scl[d] && s && prev_sda[d] && !a) begin
            in_frame[d] = 1'b1;
            nrise[d]    = 0;
            shift_in[d] = '0;
         end else if (prev_scl[d] && s && !prev_sda[d] && a) begin
            if (in_frame[d] && nrise[d] == 5) begin
               outhigh[d]   = rx_map(shift_in[d][4:1]);
               last_bits[d] = shift_in[d];
               frames_seen[d]++;
            end
            last_rise[d] = nrise[d];
            in_frame[d]  = 1'b0;
         end
         if (!prev_scl[d] && s && in_frame[d]) begin
            if (nrise[d] < 5) shift_in[d] = {shift_in[d][3:0], a};
            nrise[d]++;
         end
         if (!mon_en[d]) in_frame[d] = 1'b0;
         prev_scl[d] = s;
         prev_sda[d] = a;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic idle_check(input int d, input int cycles);
      int bad;
      bad = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if ({scl_v[d], sda_v[d], busy_v[d], done_v[d]} !== 4'b1100) bad++;
      end
      checkOutput($sformatf("idle_dut%0d_bad_cycles", d), bad, 0);
   endtask

   // Caller has already raised start with the code; acceptance is the next posedge.
   task automatic check_frame(input int d, input logic [3:0] code, input bit hold_start,
                              input logic [3:0] later_data, input int glitch_k,
                              input logic [15:0] exp_out);
      int   n, bad, first_k, f0;
      logic es, ea;
      logic [3:0] got_v, exp_v, first_got, first_exp;
      n = 24 * div_of(d);
      bad = 0;
      first_k = 0;
      first_got = '0;
      first_exp = '0;
      f0 = frames_seen[d];
      for (int k = 1; k <= n + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (!hold_start) start_v[d] = 1'b0;
            data_v[d] = later_data;
         end
         if (glitch_k > 0 && k == glitch_k) begin
            start_v[d] = 1'b1;
            data_v[d]  = 4'b0011;
         end
         if (glitch_k > 0 && k == glitch_k + 1) start_v[d] = 1'b0;
         if (k <= n) exp_lines(div_of(d), code, k, es, ea);
         else {es, ea} = 2'b11;
         got_v = {scl_v[d], sda_v[d], busy_v[d], done_v[d]};
         exp_v = {es, ea, (k <= n), (k > n)};
         if (got_v !== exp_v) begin
            if (bad == 0) begin
               first_k   = k;
               first_got = got_v;
               first_exp = exp_v;
            end
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL wave dut%0d code=%b: %0d cycles differ, first at cycle %0d scl/sda/busy/done got %b required %b",
                  d, code, bad, first_k, first_got, first_exp);
      end
      checkOutput($sformatf("rx_bits_dut%0d", d), last_bits[d], {code, 1'b0});
      checkOutput($sformatf("rx_rises_dut%0d", d), last_rise[d], 5);
      checkOutput($sformatf("rx_out_dut%0d", d), outhigh[d], exp_out);
      checkOutput($sformatf("rx_frames_dut%0d", d), frames_seen[d] - f0, 1);
   endtask

   task automatic applyStimulus(input int d, input logic [3:0] code);
      start_v[d] = 1'b1;
      data_v[d]  = code;
   endtask

   initial begin
      vec_t vecs[6];
      int   d;
      logic [3:0] code;

      vecs[0] = '{0, 4'b1010, 16'h0200};
      vecs[1] = '{1, 4'b0110, 16'h0020};
      vecs[2] = '{0, 4'b0101, 16'h0010};
      vecs[3] = '{1, 4'b1111, 16'h4000};
      vecs[4] = '{1, 4'b0000, 16'h8000};
      vecs[5] = '{0, 4'b1001, 16'h0100};

      for (int i = 0; i < 2; i++) begin
         prev_scl[i]    = 1'b1;
         prev_sda[i]    = 1'b1;
         in_frame[i]    = 1'b0;
         nrise[i]       = 0;
         shift_in[i]    = '0;
         last_bits[i]   = '0;
         last_rise[i]   = 0;
         outhigh[i]     = '0;
         frames_seen[i] = 0;
         mon_en[i]      = 1'b0;
      end
      rst_n_v = 2'b11;
      start_v = '0;
      data_v  = '0;
      #1 rst_n_v = 2'b00;
      #1;
      checkOutput("reset_dut0", {scl_v[0], sda_v[0], busy_v[0], done_v[0]}, 4'b1100);
      checkOutput("reset_dut1", {scl_v[1], sda_v[1], busy_v[1], done_v[1]}, 4'b1100);
      @(negedge clk);
      @(negedge clk);
      rst_n_v = 2'b11;
      mon_en[0] = 1'b1;
      mon_en[1] = 1'b1;
      idle_check(0, 3);
      idle_check(1, 3);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].d, vecs[i].code);
         check_frame(vecs[i].d, vecs[i].code, 1'b0, 4'($urandom), 0, vecs[i].exp_out);
         idle_check(vecs[i].d, 2);
      end

      // Start held high: second frame must be taken in the done cycle.
      applyStimulus(0, 4'b0000);
      check_frame(0, 4'b0000, 1'b1, 4'b1111, 0, 16'h8000);
      check_frame(0, 4'b1111, 1'b0, 4'b0110, 0, 16'h4000);
      idle_check(0, 3);

      // A start during a busy frame must be ignored.
      applyStimulus(0, 4'b1100);
      check_frame(0, 4'b1100, 1'b0, 4'b1100, 10, 16'h0800);
      idle_check(0, 6);

      // Reset in BIT1 HIGH; bit1=0 so sda rises while scl is high.
      mon_en[0] = 1'b0;
      applyStimulus(0, 4'b1001);
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (k == 1) start_v[0] = 1'b0;
      end
      #2 rst_n_v[0] = 1'b0;
      #1 checkOutput("reset_mid_lines", {scl_v[0], sda_v[0], busy_v[0], done_v[0]}, 4'b1100);
      @(negedge clk);
      @(negedge clk);
      rst_n_v[0] = 1'b1;
      idle_check(0, 4);
      checkOutput("reset_mid_rx_kept", outhigh[0], 16'h0800);
      mon_en[0] = 1'b1;
      applyStimulus(0, 4'b0101);
      check_frame(0, 4'b0101, 1'b0, 4'b1111, 0, 16'h0010);
      idle_check(0, 2);

      for (int i = 0; i < 8; i++) begin
         d    = int'($urandom_range(0, 1));
         code = 4'($urandom_range(0, 15));
         applyStimulus(d, code);
         check_frame(d, code, 1'b0, 4'($urandom), 0, rx_map(code));
         idle_check(d, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_i2c_tx.md
Name: nibble_i2c_tx

Overview:
- Serial transmitter that drives the two-wire scl/sda link consumed by the team's 4-bit one-hot output receiver.
- Accepts a 4-bit code from local logic and generates a complete frame from the system clock: START, 4 data bits MSB first, 1 trailer clock, STOP.
- Sits on the controller side of the board link; scl and sda are driven push-pull.

Parameters:
- CLK_DIV, 4, system-clock cycles per timing unit; legal range 1..1023.

Ports:
- clk    input   1  system clock; all logic rises on posedge.
- rst_n  input   1  asynchronous active-low reset.
- start  input   1  frame request, sampled each clk.
- data   input   4  code to send; data[3] goes first.
- scl    output  1  serial clock to the receiver.
- sda    output  1  serial data to the receiver.
- busy   output  1  high while a frame is in progress.
- done   output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values, applied asynchronously: scl=1, sda=1, busy=0, done=0, state=IDLE, all counters 0. All outputs are registered.
- Accept rule:
  - On a clk edge with start=1 and busy=0, latch data into shift register, enter START and set busy=1.
  - start while busy=1 is ignored.
  - data changes after acceptance have no effect.
- Timing unit: 1 unit = CLK_DIV clk cycles, from a counter that restarts on acceptance.
- Frame sequence (scl/sda values held for the listed units):
  - START: scl=1, sda=0, 2 units. sda falls 1 cycle after acceptance, which forms the start condition.
  - BIT3..BIT0, 4 units each:
    - LOW_A: scl=0, sda unchanged, 1 unit.
    - LOW_B: scl=0, sda=bit, 1 unit.
    - HIGH: scl=1, sda=bit, 2 units.
  - TRAIL: same 4-unit shape with bit value 0. This supplies the receiver's stop-state clock and leaves sda low.
  - STOP/GAP: scl=1, sda=1, 2 units. sda rises while scl is high, which forms the stop condition.
- Busy and done:
  - busy stays high for exactly 24*CLK_DIV cycles, starting the cycle after acceptance.
  - In the following cycle busy=0 and done=1 for that single cycle.
  - A start in the done cycle is accepted, so back-to-back frames are legal.
- Line invariants:
  - sda changes only while scl=0, except at the start and stop conditions.
  - scl and sda never change on the same clk edge.
  - Exactly 5 scl rising edges per frame. sda at those edges is data[3], data[2], data[1], data[0], 0.
- State machine:
  - States: IDLE, START, LOW_A, LOW_B, HIGH, STOP.
  - A bit index 0..4 selects data[3..0] or the trailer.
  - HIGH goes to LOW_A while index<4, else to STOP. STOP returns to IDLE.
- Reset mid-frame:
  - Both lines return high immediately; no done pulse is generated.
  - The receiver sees no valid stop, and its output keeps its old value. The next START resynchronises it.

Decomposition:
- Shared package nibble_i2c_pkg holds:
  - state encoding constants;
  - unit counts: START_UNITS=2, LOW_A_UNITS=1, LOW_B_UNITS=1, HIGH_UNITS=2, STOP_UNITS=2;
  - NBITS=4 and FRAME_UNITS=24.
- Sub-module i2c_unit_timer:
  - Counter of width clog2(CLK_DIV), with sync clear on acceptance.
  - Emits a 1-cycle unit tick every CLK_DIV cycles.
- The top level holds the FSM, unit counter, bit index, shift register and output registers.

Test Plan:
- CLK_DIV=4, data=4'b1010, one start pulse:
  - sda at the 5 scl rises is 1,0,1,0,0.
  - busy is high for 96 cycles and done pulses once.
  - A behavioural receiver model shows outhigh=16'h0200.
- data=4'b0000 followed by data=4'b1111, start held high continuously:
  - The second frame is accepted in the done cycle of the first, with no idle gap beyond STOP/GAP.
  - The receiver shows 16'h8000, then 16'h4000.
- Start pulse with data=4'b0011 at cycle 10 of a busy frame: ignored. The current frame completes unchanged and only one done pulse occurs.
- rst_n asserted in the BIT1 HIGH phase:
  - scl=1, sda=1, busy=0 immediately, and no done pulse.
  - A following frame with data=4'b0101 decodes to 16'h0010.
- CLK_DIV=1, data=4'b0110:
  - Frame is 24 cycles and the receiver shows 16'h0020.
  - A checker confirms no scl/sda change on the same edge and sda stable while scl=1 except at start and stop.
